alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Chunk-serial Y86-style ALU: ADD/SUB/AND/XOR over WIDTH bits, CHUNK bits per cycle, valid/ready handshake.
// Define ALU_SEQ_CC_EN to build the {ZF,SF,OF} condition-code registers; otherwise cc is tied to zero.
module alu_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = CHUNK + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             last_c;
    logic             accept_c;
    logic [SUM_W-1:0] sum_c;
    logic [CHUNK-1:0] chunk_res_c;
    logic [WIDTH-1:0] full_res_c;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign accept_c  = in_valid && (state_q == IDLE);
    assign last_c    = (cnt_q == CNT_W'(N - 1));

    // Operands shift right each BUSY cycle, so the active chunk is always in the low bits.
    assign sum_c = {1'b0, b_q[CHUNK-1:0]} + {1'b0, a_q[CHUNK-1:0]} + SUM_W'(carry_q);

    always_comb begin
        chunk_res_c = sum_c[CHUNK-1:0];
        case (op_q)
            OP_ADD:  chunk_res_c = sum_c[CHUNK-1:0];
            OP_SUB:  chunk_res_c = sum_c[CHUNK-1:0];
            OP_AND:  chunk_res_c = b_q[CHUNK-1:0] & a_q[CHUNK-1:0];
            OP_XOR:  chunk_res_c = b_q[CHUNK-1:0] ^ a_q[CHUNK-1:0];
            default: chunk_res_c = sum_c[CHUNK-1:0];
        endcase
    end

    // Finished chunks enter from the top; after N cycles the word is fully assembled.
    assign full_res_c = (work_q >> CHUNK) | (WIDTH'(chunk_res_c) << (WIDTH - CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last_c) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: SUB is b + ~a + 1, so a is stored inverted with carry-in preset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (accept_c) begin
            op_q    <= op;
            a_q     <= (op == OP_SUB) ? ~a : a;
            b_q     <= b;
            carry_q <= (op == OP_SUB);
            cnt_q   <= '0;
        end else if (state_q == BUSY) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= sum_c[CHUNK];
            work_q  <= full_res_c;
            cnt_q   <= last_c ? '0 : cnt_q + CNT_W'(1);
            if (last_c) result_q <= full_res_c;
        end
    end

`ifdef ALU_SEQ_CC_EN
    logic [2:0] cc_q;
    logic       of_c;

    // With a pre-inverted for SUB, both ADD and SUB overflow reduce to the adder rule on the top chunk.
    assign of_c = ~op_q[1] && (a_q[CHUNK-1] == b_q[CHUNK-1]) && (chunk_res_c[CHUNK-1] != b_q[CHUNK-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b000;
        end else if ((state_q == BUSY) && last_c) begin
            cc_q <= {(full_res_c == '0), full_res_c[WIDTH-1], of_c};
        end
    end

    assign cc = cc_q;
`else
    assign cc = 3'b000;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: chunked arithmetic, flags, latency, backpressure, reset abort, single-chunk build.
module tb_alu_seq;

    localparam int unsigned WIDTH = 64;

`ifdef ALU_SEQ_CC_EN
    localparam logic [2:0] CC_MASK = 3'b111;
`else
    localparam logic [2:0] CC_MASK = 3'b000;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       cc;

    logic             in_valid1;
    logic             in_ready1;
    logic             out_valid1;
    logic             out_ready1;
    logic [WIDTH-1:0] result1;
    logic [2:0]       cc1;

    int vectors;
    int miscompares;

    alu_seq #(.WIDTH(64), .CHUNK(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cc(cc)
    );

    alu_seq #(.WIDTH(64), .CHUNK(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .cc(cc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, hold result for 'hold' extra cycles, then retire it.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] va,
                          input logic [63:0] vb, input logic [63:0] er, input logic [2:0] ec,
                          input int hold);
        int lat;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        check($sformatf("%s in_ready_after_accept", tag), 64'(in_ready), 64'd0);
        op = ~o; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check($sformatf("%s latency", tag), 64'(lat), 64'd4);
        check($sformatf("%s result", tag), result, er);
        check($sformatf("%s cc", tag), 64'(cc), 64'(ec & CC_MASK));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s hold%0d out_valid", tag, i), 64'(out_valid), 64'd1);
            check($sformatf("%s hold%0d in_ready", tag, i), 64'(in_ready), 64'd0);
            check($sformatf("%s hold%0d result", tag, i), result, er);
            check($sformatf("%s hold%0d cc", tag, i), 64'(cc), 64'(ec & CC_MASK));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("%s out_valid_after_take", tag), 64'(out_valid), 64'd0);
        check($sformatf("%s in_ready_after_take", tag), 64'(in_ready), 64'd1);
        check($sformatf("%s result_persist", tag), result, er);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_valid1   = 1'b0;
        out_ready   = 1'b0;
        out_ready1  = 1'b0;
        op          = 2'd0;
        a           = '0;
        b           = '0;
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", result, 64'd0);
        check("reset cc", 64'(cc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);

        run_op("add_ovf",   2'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3'b011, 0);
        run_op("add_carry", 2'd0, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 3'b000, 0);
        run_op("sub_zero",  2'd1, 64'd5, 64'd5, 64'd0, 3'b100, 0);
        run_op("sub_ovf",   2'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 0);
        run_op("and",       2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
               64'hF000_F000_F000_F000, 3'b010, 0);
        run_op("xor_ff",    2'd3, 64'hFF, 64'hFF, 64'd0, 3'b100, 0);
        run_op("add_neg",   2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 0);
        run_op("sub_neg",   2'd1, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 0);
        run_op("backpress", 2'd0, 64'h1234, 64'd1, 64'h1235, 3'b000, 3);

        // Reset during BUSY cycle 2 of an ADD.
        @(negedge clk);
        in_valid = 1'b1; op = 2'd0; a = 64'd3; b = 64'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset result", result, 64'd0);
        check("midreset cc", 64'(cc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midreset no_stale_done", 64'(out_valid), 64'd0);
        check("midreset in_ready", 64'(in_ready), 64'd1);
        run_op("post_reset", 2'd1, 64'd1, 64'd10, 64'd9, 3'b000, 0);

        // Single-chunk instance: latency of one edge.
        @(negedge clk);
        in_valid1 = 1'b1; op = 2'd0; a = 64'd1; b = 64'h7FFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("n1 in_ready_busy", 64'(in_ready1), 64'd0);
        check("n1 out_valid_busy", 64'(out_valid1), 64'd0);
        @(posedge clk); #1;
        check("n1 out_valid", 64'(out_valid1), 64'd1);
        check("n1 result", result1, 64'h8000_0000_0000_0000);
        check("n1 cc", 64'(cc1), 64'(3'b011 & CC_MASK));
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("n1 in_ready_after_take", 64'(in_ready1), 64'd1);
        check("main idle_untouched", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
